// File: rtl/svd_pkg.sv
// Shared types, widths and helpers for the SVD host loader and its read sequencer.
package svd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MASK,
      WAIT_RDY,
      READ
   } state_t;

   localparam int ELEM_W   = 10;
   localparam int BEAT_W   = 5;
   localparam int UV_W     = 8;
   localparam int S_W      = 7;
   localparam int N_ELEM   = 4;
   localparam int LOAD_CYC = 9;

   // Picks the low or high 5-bit half of matrix element k.
   function automatic logic [BEAT_W-1:0] beatOf(input logic [N_ELEM*ELEM_W-1:0] mat,
                                                input logic [1:0] k,
                                                input logic hi);
      logic [ELEM_W-1:0] e;
      e = mat[k*ELEM_W +: ELEM_W];
      return hi ? e[ELEM_W-1:BEAT_W] : e[BEAT_W-1:0];
   endfunction

endpackage

// File: rtl/svd_read_sequencer.sv
// Read-back sequencer: walks the four result slots (3,2,2,2 cycles), driving oe/sel
// and flagging the last cycle of each slot as the capture point.
module svd_read_sequencer
   import svd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       go_i,
   output logic       oe_o,
   output logic [1:0] sel_o,
   output logic       cap_o,
   output logic       last_o
);

   logic       active_q;
   logic [3:0] cnt_q;
   logic [1:0] sel_q;

   // Slot k ends at read cycle 2k+2, which gives slot 0 its extra cycle.
   always_comb begin
      cap_o  = active_q && (cnt_q == (4'({sel_q, 1'b0}) + 4'd2));
      last_o = cap_o && (sel_q == 2'd3);
      oe_o   = active_q;
      sel_o  = sel_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         sel_q    <= '0;
      end else if (go_i) begin
         active_q <= 1'b1;
         cnt_q    <= '0;
         sel_q    <= '0;
      end else if (active_q) begin
         if (last_o) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 4'd1;
            if (cap_o) begin
               sel_q <= sel_q + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/svd_host_loader.sv
// Host-side master for the SVD core: loads a 2x2 Q8.2 matrix as 5-bit beats, waits for
// ready, then reads back U/V and S. `define SVD_HOST_TIMEOUT_EN adds a WAIT_RDY timeout.
module svd_host_loader
   import svd_pkg::*;
#(
   parameter int unsigned READY_MASK = 4
`ifdef SVD_HOST_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [N_ELEM*ELEM_W-1:0]   mat_i,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [N_ELEM*UV_W-1:0]     uv_o,
   output logic [N_ELEM*S_W-1:0]      s_o,
   output logic                       svd_we,
   output logic                       svd_oe,
   output logic [1:0]                 svd_sel,
   output logic [BEAT_W-1:0]          svd_data,
   input  logic                       svd_ready,
   input  logic [UV_W-1:0]            svd_uv,
   input  logic [S_W-1:0]             svd_s
);

   localparam int MaskW = (READY_MASK > 1) ? $clog2(READY_MASK) : 1;

   state_t                      state_q;
   logic [N_ELEM*ELEM_W-1:0]    mat_q;
   logic [3:0]                  beat_q;
   logic [MaskW-1:0]            mask_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        we_q;
   logic [1:0]                  sel_q;
   logic [BEAT_W-1:0]           data_q;
   logic [BEAT_W-1:0]           data_d;
   logic [N_ELEM*UV_W-1:0]      uv_q;
   logic [N_ELEM*S_W-1:0]       s_q;
   logic                        rdGo;
   logic                        rdOe;
   logic [1:0]                  rdSel;
   logic                        rdCap;
   logic                        rdLast;
`ifdef SVD_HOST_TIMEOUT_EN
   logic                        err_q;
   logic [15:0]                 tmo_q;
`endif

   // Beat n+1 carries element n>>1; odd n means the next beat is the upper half.
   always_comb begin
      data_d = beatOf(mat_q, beat_q[2:1], beat_q[0]);
      rdGo   = (state_q == WAIT_RDY) && svd_ready;
   end

   svd_read_sequencer u_rdseq (
      .clk    (clk),
      .rst    (rst),
      .go_i   (rdGo),
      .oe_o   (rdOe),
      .sel_o  (rdSel),
      .cap_o  (rdCap),
      .last_o (rdLast)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mat_q   <= '0;
         beat_q  <= '0;
         mask_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         data_q  <= '0;
`ifdef SVD_HOST_TIMEOUT_EN
         err_q   <= 1'b0;
         tmo_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= LOAD;
                  mat_q   <= mat_i;
                  busy_q  <= 1'b1;
                  we_q    <= 1'b1;
                  sel_q   <= '0;
                  data_q  <= '0;
                  beat_q  <= '0;
`ifdef SVD_HOST_TIMEOUT_EN
                  err_q   <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (beat_q == 4'(LOAD_CYC - 1)) begin
                  state_q <= MASK;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  data_q  <= '0;
                  mask_q  <= '0;
               end else begin
                  beat_q <= beat_q + 4'd1;
                  sel_q  <= beat_q[2:1];
                  data_q <= data_d;
               end
            end
            MASK: begin
               if (mask_q == MaskW'(READY_MASK - 1)) begin
                  state_q <= WAIT_RDY;
`ifdef SVD_HOST_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end else begin
                  mask_q <= mask_q + 1'b1;
               end
            end
            WAIT_RDY: begin
               if (svd_ready) begin
                  state_q <= READ;
               end
`ifdef SVD_HOST_TIMEOUT_EN
               else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
`endif
            end
            READ: begin
               if (rdLast) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Result lanes are overwritten one by one as each read slot closes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uv_q <= '0;
         s_q  <= '0;
      end else if (rdCap) begin
         uv_q[rdSel*UV_W +: UV_W] <= svd_uv;
         s_q[rdSel*S_W +: S_W]    <= svd_s;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign uv_o     = uv_q;
   assign s_o      = s_q;
   assign svd_we   = we_q;
   assign svd_oe   = rdOe;
   assign svd_sel  = sel_q | rdSel;
   assign svd_data = data_q;
`ifdef SVD_HOST_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_svd_host_loader.sv
// Self-checking bench for svd_host_loader: cycle schedule model plus directed literal checks.
// Timeout scenario is only exercised when SVD_HOST_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_svd_host_loader;

   localparam logic [39:0] MAT_A = {10'h390, 10'h320, 10'h384, 10'h0AC};
   localparam logic [39:0] MAT_B = {10'h001, 10'h3FF, 10'h155, 10'h2AA};
`ifdef SVD_HOST_TIMEOUT_EN
   localparam int TMO = 16;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [39:0] mat_i = '0;
   logic        busy, done, err;
   logic [31:0] uv_o;
   logic [27:0] s_o;
   logic        svd_we, svd_oe;
   logic [1:0]  svd_sel;
   logic [4:0]  svd_data;
   logic        svd_ready = 1'b0;
   logic [7:0]  svd_uv;
   logic [6:0]  svd_s;
   logic [7:0]  uvMul = 8'h11;
   logic [6:0]  sOff = 7'd5;

   int nTests = 0;
   int nFail = 0;
   int cycleNo = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycleNo++;

   // Core stand-in: result values depend only on the selected element.
   assign svd_uv = 8'(uvMul * ({6'd0, svd_sel} + 8'd1));
   assign svd_s  = {5'd0, svd_sel} + sOff;

   svd_host_loader #(
      .READY_MASK(4)
`ifdef SVD_HOST_TIMEOUT_EN
      , .TIMEOUT_CYC(TMO)
`endif
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mat_i(mat_i),
      .busy(busy), .done(done), .err(err), .uv_o(uv_o), .s_o(s_o),
      .svd_we(svd_we), .svd_oe(svd_oe), .svd_sel(svd_sel), .svd_data(svd_data),
      .svd_ready(svd_ready), .svd_uv(svd_uv), .svd_s(svd_s)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Schedule model: position in the transaction is counted from the accepted start.
   // Cycle 1..9 load, 10..13 mask, 14.. wait, then 9 read cycles and one done cycle.
   bit          mActive = 0;
   bit          mDone = 0;
   bit          mErr = 0;
   int          mCyc = 0;
   int          mRdBegin = 0;
   int          mWait = 0;
   logic [39:0] mMat = '0;
   logic [31:0] mUv = '0;
   logic [27:0] mS = '0;

   always @(posedge clk) begin : model
      int r, k;
      if (!rst) begin
         mActive = 0; mDone = 0; mErr = 0; mCyc = 0; mRdBegin = 0; mWait = 0;
         mUv = '0; mS = '0;
      end else begin
         mDone = 0;
         if (mActive) begin
            if (mRdBegin == 0 && mCyc >= 14) begin
               mWait++;
               if (svd_ready) mRdBegin = mCyc + 1;
`ifdef SVD_HOST_TIMEOUT_EN
               else if (mWait == TMO) begin
                  mActive = 0; mDone = 1; mErr = 1;
               end
`endif
            end
            if (mRdBegin != 0) begin
               r = mCyc - mRdBegin;
               if (r >= 2 && r <= 8 && (r % 2) == 0) begin
                  k = r / 2 - 1;
                  mUv[k*8 +: 8] = 8'(uvMul * (k + 1));
                  mS[k*7 +: 7]  = 7'(sOff + 7'(k));
               end
            end
            mCyc++;
            if (mActive && mRdBegin != 0 && mCyc == mRdBegin + 9) begin
               mActive = 0; mDone = 1;
            end
         end else if (start) begin
            mActive = 1; mCyc = 1; mRdBegin = 0; mWait = 0; mMat = mat_i; mErr = 0;
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic       eWe, eOe;
      logic [1:0] eSel;
      logic [4:0] eData;
      int n, k, r;
      eWe = 0; eOe = 0; eSel = 0; eData = 0;
      if (mActive && mCyc >= 1 && mCyc <= 9) begin
         eWe = 1;
         n = mCyc - 1;
         if (n > 0) begin
            k = (n - 1) / 2;
            eSel = 2'(k);
            eData = (n % 2 == 1) ? mMat[k*10 +: 5] : mMat[k*10+5 +: 5];
         end
      end
      if (mActive && mRdBegin != 0 && mCyc >= mRdBegin && mCyc < mRdBegin + 9) begin
         eOe = 1;
         r = mCyc - mRdBegin;
         eSel = (r < 3) ? 2'd0 : 2'((r - 1) / 2);
      end
      checkOutput("ctrl", 64'({busy, done, err, svd_we, svd_oe}), 64'({mActive, mDone, mErr, eWe, eOe}));
      checkOutput("sel_data", 64'({svd_sel, svd_data}), 64'({eSel, eData}));
      checkOutput("results", 64'({uv_o, s_o}), 64'({mUv, mS}));
   end

   logic [6:0] beatQ[$];
   int   doneCnt = 0;
   int   firstOeCyc = -1;
   logic oePrev = 0;

   always @(negedge clk) begin
      if (svd_we) beatQ.push_back({svd_sel, svd_data});
      if (done) doneCnt++;
      if (svd_oe && !oePrev && firstOeCyc < 0) firstOeCyc = cycleNo;
      oePrev = svd_oe;
   end

   task automatic applyStimulus(input logic [39:0] m, output int sCyc);
      @(negedge clk); #2;
      start = 1'b1;
      mat_i = m;
      sCyc = cycleNo;
      @(negedge clk); #2;
      start = 1'b0;
   endtask

   task automatic waitUntilCycle(input int c);
      while (cycleNo < c) @(negedge clk);
      #2;
   endtask

   task automatic waitDone(input int maxCyc, output int dCyc);
      dCyc = -1;
      for (int i = 0; i < maxCyc; i++) begin
         @(negedge clk); #1;
         if (done) begin
            dCyc = cycleNo;
            break;
         end
      end
      if (dCyc < 0) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL done_wait: got no done, expected one within %0d cycles", maxCyc);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s, d, unused;
      logic [6:0] expBeats[9];
      expBeats = '{7'b00_00000, 7'b00_01100, 7'b00_00101, 7'b01_00100, 7'b01_11100,
                   7'b10_00000, 7'b10_11001, 7'b11_10000, 7'b11_11100};

      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk); #1;
      checkOutput("reset_ctrl", 64'({busy, done, err, svd_we, svd_oe, svd_sel, svd_data}), 64'd0);
      checkOutput("reset_results", 64'({uv_o, s_o}), 64'd0);

      // Load order, mask timing and readback, with a second start ignored mid-load.
      svd_ready = 1'b1;
      uvMul = 8'h11; sOff = 7'd5;
      beatQ.delete(); doneCnt = 0; firstOeCyc = -1;
      applyStimulus(MAT_A, s);
      applyStimulus(40'hFF_FFFF_FFFF, unused);
      waitDone(60, d);
      checkOutput("done_latency", 64'(d - s), 64'd24);
      checkOutput("oe_rise", 64'(firstOeCyc - s), 64'd15);
      checkOutput("beat_count", 64'(beatQ.size()), 64'd9);
      for (int i = 0; i < 9 && i < beatQ.size(); i++)
         checkOutput("beat", 64'(beatQ[i]), 64'(expBeats[i]));
      checkOutput("uv_o_a", 64'(uv_o), 64'h44332211);
      checkOutput("s_o_a", 64'(s_o), 64'({7'd8, 7'd7, 7'd6, 7'd5}));
      repeat (30) @(negedge clk);
      checkOutput("done_count", 64'(doneCnt), 64'd1);

      // Ready arrives late: seven WAIT_RDY cycles.
      svd_ready = 1'b0;
      uvMul = 8'h21; sOff = 7'd40;
      applyStimulus(MAT_B, s);
      waitUntilCycle(s + 20);
      svd_ready = 1'b1;
      waitDone(80, d);
      checkOutput("wait_latency", 64'(d - s), 64'd30);
      checkOutput("uv_o_b", 64'(uv_o), 64'h84634221);
      checkOutput("s_o_b", 64'(s_o), 64'({7'd43, 7'd42, 7'd41, 7'd40}));

      // Async reset in the middle of the read phase, then a clean rerun.
      applyStimulus(MAT_A, s);
      waitUntilCycle(s + 18);
      rst = 1'b0;
      #1;
      checkOutput("midreset_ctrl", 64'({busy, done, err, svd_we, svd_oe, svd_sel, svd_data}), 64'd0);
      checkOutput("midreset_results", 64'({uv_o, s_o}), 64'd0);
      @(posedge clk); #2 rst = 1'b1;
      uvMul = 8'h05; sOff = 7'd1;
      applyStimulus(MAT_B, s);
      waitDone(60, d);
      checkOutput("rerun_latency", 64'(d - s), 64'd24);
      checkOutput("uv_o_c", 64'(uv_o), 64'h140F0A05);
      checkOutput("s_o_c", 64'(s_o), 64'({7'd4, 7'd3, 7'd2, 7'd1}));

`ifdef SVD_HOST_TIMEOUT_EN
      // Ready never comes: abort after TMO wait cycles, results untouched.
      svd_ready = 1'b0;
      applyStimulus(MAT_A, s);
      waitDone(80, d);
      checkOutput("tmo_latency", 64'(d - s), 64'(14 + TMO));
      checkOutput("tmo_err", 64'(err), 64'd1);
      checkOutput("tmo_uv_kept", 64'(uv_o), 64'h140F0A05);
      repeat (3) @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
